// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the weight-stationary MAC array.
//
// On an accepted start, it streams `row` weight words from the shared SRAM
// (inst_w=01) and waits for the row-to-row instruction pipeline to settle. It
// then streams `len` activation words (inst_w=10), counts mac_array valid
// pulses until `len` have been seen, and pulses done for one cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      job request, honoured only when idle
//   abort      terminates the current job (no done)
//   len        activation vectors to execute, latched at start
//   w_base     weight base address, latched at start
//   x_base     activation base address, latched at start
//   index_cfg  index select, latched at start
//   valid      mac_array column valid
//   mem_cen    SRAM chip enable, active-low
//   mem_addr   SRAM read address (wraps modulo 2^addr_bw)
//   inst_w     array instruction: [1]=execute, [0]=kernel load
//   index_w    latched index_cfg
//   ofifo_wr   valid gated by EXEC/DRAIN
//   busy       high whenever not idle
//   done       one-cycle completion pulse
//   perf_cyc   busy-cycle counter (only with MAC_SEQ_PERF_EN defined)
//
// Build option: define MAC_SEQ_PERF_EN to add the perf_cyc output and counter.

module mac_seq_ctrl #(
  parameter int unsigned row             = 8,
  parameter int unsigned col             = 8,
  parameter int unsigned index_selection = 2,
  parameter int unsigned addr_bw         = 11,
  parameter int unsigned len_bw          = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [len_bw-1:0]              len,
  input  logic [addr_bw-1:0]             w_base,
  input  logic [addr_bw-1:0]             x_base,
  input  logic [row/index_selection-1:0] index_cfg,
  input  logic [col-1:0]                 valid,
  output logic                           mem_cen,
  output logic [addr_bw-1:0]             mem_addr,
  output logic [1:0]                     inst_w,
  output logic [row/index_selection-1:0] index_w,
  output logic [col-1:0]                 ofifo_wr,
  output logic                           busy,
  output logic                           done
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]                    perf_cyc
`endif
);

  localparam int unsigned IdxW      = row / index_selection;
  // Instruction pipeline settle time between the kernel load and execution.
  localparam int unsigned GapCycles = IdxW + 1;
  localparam int unsigned RowCntW   = $clog2(row + GapCycles + 1);
  localparam int unsigned CntW      = (len_bw > RowCntW) ? len_bw : RowCntW;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGap,
    StExec,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [len_bw-1:0]   vld_cnt_q, vld_cnt_d;
  logic [len_bw-1:0]   vld_cnt_inc;
  logic [len_bw-1:0]   len_q;
  logic [addr_bw-1:0]  w_base_q, x_base_q;
  logic [IdxW-1:0]     index_q;
  logic [1:0]          inst_w_q, inst_w_d;
  logic                start_ok;
  logic                count_vld;
  logic                in_exec_drain;

  assign start_ok      = (state_q == StIdle) && start && !abort;
  assign in_exec_drain = (state_q == StExec) || (state_q == StDrain);
  assign count_vld     = in_exec_drain && valid[0];
  assign vld_cnt_inc   = vld_cnt_q + len_bw'(count_vld);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      vld_cnt_q <= '0;
      len_q     <= '0;
      w_base_q  <= '0;
      x_base_q  <= '0;
      index_q   <= '0;
      inst_w_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vld_cnt_q <= vld_cnt_d;
      inst_w_q  <= inst_w_d;
      if (start_ok) begin
        len_q    <= len;
        w_base_q <= w_base;
        x_base_q <= x_base;
        index_q  <= index_cfg;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vld_cnt_d = vld_cnt_q;
    inst_w_d  = 2'b00;

    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      cnt_d     = '0;
      vld_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_d   = StLoad;
            cnt_d     = '0;
            vld_cnt_d = '0;
          end
        end
        StLoad: begin
          // inst_w trails the address by one cycle to match SRAM read latency.
          inst_w_d = 2'b01;
          if (cnt_q == CntW'(row - 1)) begin
            state_d = StGap;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == CntW'(GapCycles - 1)) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? StDone : StExec;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StExec: begin
          inst_w_d  = 2'b10;
          vld_cnt_d = vld_cnt_inc;
          if (cnt_q == CntW'(len_q - 1'b1)) begin
            state_d = StDrain;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDrain: begin
          vld_cnt_d = vld_cnt_inc;
          // Use the incremented count so done follows the last pulse by one cycle.
          if (vld_cnt_inc >= len_q) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d   = StIdle;
          vld_cnt_d = '0;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    mem_cen  = 1'b1;
    mem_addr = '0;
    case (state_q)
      StLoad: begin
        mem_cen  = 1'b0;
        mem_addr = w_base_q + addr_bw'(cnt_q);
      end
      StExec: begin
        mem_cen  = 1'b0;
        mem_addr = x_base_q + addr_bw'(cnt_q);
      end
      default: begin
        mem_cen  = 1'b1;
        mem_addr = '0;
      end
    endcase
  end

  assign inst_w   = inst_w_q;
  assign index_w  = index_q;
  assign ofifo_wr = valid & {col{in_exec_drain}};
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Cleared by an accepted start, then counts every busy cycle (DONE included).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if (busy) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_cyc = perf_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: randomized bench for mac_seq_ctrl with a job-timeline model.
// The model tracks each job as a cycle index k since the accepted start and
// derives expected outputs from the phase boundaries (load, gap, exec, drain).

module tb_mac_seq_ctrl;

  localparam int R     = 8;
  localparam int G     = 8 / 2 + 1;
  localparam int AMASK = 'h7ff;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  len = '0;
  logic [10:0] w_base = '0;
  logic [10:0] x_base = '0;
  logic [3:0]  index_cfg = '0;
  logic [7:0]  valid = '0;
  logic        mem_cen;
  logic [10:0] mem_addr;
  logic [1:0]  inst_w;
  logic [3:0]  index_w;
  logic [7:0]  ofifo_wr;
  logic        busy;
  logic        done;
`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perf_cyc;
`endif

  mac_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .len       (len),
    .w_base    (w_base),
    .x_base    (x_base),
    .index_cfg (index_cfg),
    .valid     (valid),
    .mem_cen   (mem_cen),
    .mem_addr  (mem_addr),
    .inst_w    (inst_w),
    .index_w   (index_w),
    .ofifo_wr  (ofifo_wr),
    .busy      (busy),
    .done      (done)
`ifdef MAC_SEQ_PERF_EN
    ,
    .perf_cyc  (perf_cyc)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the job in flight.
  bit          m_active;
  bit          m_done_now;
  int          m_k;
  int          m_len;
  int          m_wb;
  int          m_xb;
  int          m_idx;
  int          m_vcnt;
  int unsigned m_perf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_done_now = 1'b0;
    m_k        = 0;
    m_len      = 0;
    m_wb       = 0;
    m_xb       = 0;
    m_idx      = 0;
    m_vcnt     = 0;
    m_perf     = 0;
  endtask

  task automatic check_reset_values();
    check_eq("rst_mem_cen", 64'(mem_cen), 64'd1);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_inst_w", 64'(inst_w), 64'd0);
    check_eq("rst_index_w", 64'(index_w), 64'd0);
    check_eq("rst_ofifo_wr", 64'(ofifo_wr), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
`ifdef MAC_SEQ_PERF_EN
    check_eq("rst_perf_cyc", 64'(perf_cyc), 64'd0);
`endif
  endtask

  task automatic check_outputs();
    int ex_start;
    int ex_end;
    bit e_cen;
    int e_addr;
    int e_inst;
    logic [7:0] e_of;
    ex_start = R + G + 1;
    ex_end   = R + G + m_len;
    e_cen    = 1'b1;
    e_addr   = 0;
    e_inst   = 0;
    e_of     = '0;
    if (m_active) begin
      if (m_k >= 1 && m_k <= R) begin
        e_cen  = 1'b0;
        e_addr = (m_wb + m_k - 1) & AMASK;
      end
      if (m_len > 0 && m_k >= ex_start && m_k <= ex_end) begin
        e_cen  = 1'b0;
        e_addr = (m_xb + m_k - ex_start) & AMASK;
      end
      if (m_k >= 2 && m_k <= R + 1) e_inst = 1;
      if (m_len > 0 && m_k >= ex_start + 1 && m_k <= ex_end + 1) e_inst = 2;
      if (m_len > 0 && m_k >= ex_start && !m_done_now) e_of = valid;
    end
    check_eq("mem_cen", 64'(mem_cen), 64'(e_cen));
    if (!e_cen) check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
    check_eq("inst_w", 64'(inst_w), 64'(e_inst));
    check_eq("index_w", 64'(index_w), 64'(m_idx));
    check_eq("ofifo_wr", 64'(ofifo_wr), 64'(e_of));
    check_eq("busy", 64'(busy), 64'(m_active));
    check_eq("done", 64'(done), 64'(m_active && m_done_now));
`ifdef MAC_SEQ_PERF_EN
    check_eq("perf_cyc", 64'(perf_cyc), 64'(m_perf));
`endif
  endtask

  // Advance the model across one rising edge using the inputs just applied.
  task automatic model_step();
    int ex_start;
    int ex_end;
    bit was_busy;
    bit accept;
    ex_start = R + G + 1;
    ex_end   = R + G + m_len;
    was_busy = m_active;
    accept   = !m_active && start && !abort;
    if (m_active) begin
      if (abort || m_done_now) begin
        m_active   = 1'b0;
        m_done_now = 1'b0;
      end else begin
        if (m_len > 0 && m_k >= ex_start && valid[0]) m_vcnt++;
        if (m_len == 0 && m_k == R + G) m_done_now = 1'b1;
        if (m_len > 0 && m_k >= ex_end + 1 && m_vcnt >= m_len) m_done_now = 1'b1;
        m_k++;
      end
    end else if (accept) begin
      m_active   = 1'b1;
      m_done_now = 1'b0;
      m_k        = 1;
      m_vcnt     = 0;
      m_len      = int'(len);
      m_wb       = int'(w_base);
      m_xb       = int'(x_base);
      m_idx      = int'(index_cfg);
    end
    if (accept) m_perf = 0;
    else if (was_busy) m_perf++;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 700 || cyc == 1400) begin
        #2 reset = 1'b1;
        #1 check_reset_values();
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
      end
      if (cyc < 30) begin
        // Opening job with known parameters and no abort.
        start     = (cyc == 0);
        abort     = 1'b0;
        len       = 8'd4;
        w_base    = 11'h010;
        x_base    = 11'h040;
        index_cfg = 4'ha;
      end else begin
        start     = m_active ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
        abort     = m_active ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 7) == 0);
        len       = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
        w_base    = ($urandom_range(0, 3) == 0) ? 11'h7fc : 11'($urandom);
        x_base    = ($urandom_range(0, 3) == 0) ? 11'h7fe : 11'($urandom);
        index_cfg = 4'($urandom);
      end
      valid = 8'($urandom);
      #2 check_outputs();
      @(posedge clk);
      model_step();
      #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
